zap_branch_resolve: RTL and testbench

Resolves branches in the ALU stage and drives the training/flush feedback that the branch predictor consumes. Compares the 2-bit predictor state carried with each instruction against the actual branch outcome. Emits a registered misprediction clear (with redirect PC) or a confirm, both tagged with the instruction PC. Suppresses wrong-path resolutions for a programmable shadow window after a clear, and keeps saturating branch/mispredict counters.

---
 rtl/zap_branch_resolve_pkg.sv | 25 ++
 rtl/zap_sat_counter.sv | 23 ++
 rtl/zap_branch_resolve.sv | 132 +++++++++++++
 tb/tb_zap_branch_resolve.sv | 166 ++++++++++++++++
 4 files changed

// File: rtl/zap_branch_resolve_pkg.sv
// Shared encodings for branch resolution: predictor states, PC offsets, FSM states.
package zap_branch_resolve_pkg;

    // 2-bit predictor state encodings carried with each instruction
    localparam logic [1:0] BSTATE_SNT = 2'd0;
    localparam logic [1:0] BSTATE_WNT = 2'd1;
    localparam logic [1:0] BSTATE_WT  = 2'd2;
    localparam logic [1:0] BSTATE_ST  = 2'd3;

    // Bit of the predictor state that means "predicted taken"
    localparam int PRED_TAKEN_BIT = 1;

    // Distance from the instruction PC to the pipeline's PC+8/PC+4 value
    localparam logic [31:0] ARM_PC_OFF    = 32'd8;
    localparam logic [31:0] THUMB_PC_OFF  = 32'd4;
    // Size of one instruction, used for the sequential (fall-through) address
    localparam logic [31:0] ARM_SEQ_OFF   = 32'd4;
    localparam logic [31:0] THUMB_SEQ_OFF = 32'd2;

    typedef enum logic {
        ST_RUN    = 1'b0,
        ST_SHADOW = 1'b1
    } br_state_t;

endpackage

// File: rtl/zap_sat_counter.sv
// Event counter that sticks at all-ones instead of wrapping.
module zap_sat_counter #(
    parameter int W = 32
) (
    input  logic         i_clk,
    input  logic         i_reset_n,
    input  logic         i_en,
    output logic [W-1:0] o_cnt
);

    logic [W-1:0] r_cnt;

    // Count enabled events; hold once the maximum value is reached
    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n)
            r_cnt <= '0;
        else if (i_en && (r_cnt != '1))
            r_cnt <= r_cnt + W'(1);
    end

    assign o_cnt = r_cnt;

endmodule

// File: rtl/zap_branch_resolve.sv
// ALU-stage branch resolution: compares the carried prediction with the actual
// outcome, emits registered clear/confirm training pulses, suppresses wrong-path
// branches for a shadow window after a clear, and counts branches/mispredicts.
module zap_branch_resolve
    import zap_branch_resolve_pkg::*;
#(
    parameter int SHADOW_CYCLES = 1
) (
    input  logic        i_clk,
    input  logic        i_reset_n,
    input  logic        i_clear_from_writeback,
    input  logic        i_data_stall,
    input  logic        i_val,
    input  logic        i_is_branch,
    input  logic        i_taken,
    input  logic [1:0]  i_bstate,
    input  logic        i_thumb,
    input  logic [31:0] i_pc_plus_8,
    input  logic [31:0] i_target,
    output logic        o_clear_from_alu,
    output logic        o_confirm_from_alu,
    output logic [31:0] o_pc_from_alu,
    output logic [31:0] o_redirect_pc,
    output logic [31:0] o_branch_cnt,
    output logic [31:0] o_mispredict_cnt
);

    localparam logic [3:0] SHADOW_LOAD = 4'(SHADOW_CYCLES);

    br_state_t   r_state, w_state_nxt;
    logic [3:0]  r_shadow_cnt, w_shadow_nxt;
    logic        r_clear, r_confirm;
    logic [31:0] r_pc, r_redirect;

    logic        w_accept, w_mispred, w_pred;
    logic [31:0] w_pc, w_seq;
    logic        w_unused;

    // Only the predicted-direction bit matters for resolution
    assign w_unused  = i_bstate[0];

    assign w_pred    = i_bstate[PRED_TAKEN_BIT];
    assign w_mispred = (w_pred != i_taken);
    assign w_accept  = i_val & i_is_branch & (r_state == ST_RUN)
                     & ~i_data_stall & ~i_clear_from_writeback;
    assign w_pc      = i_pc_plus_8 - (i_thumb ? THUMB_PC_OFF : ARM_PC_OFF);
    assign w_seq     = w_pc + (i_thumb ? THUMB_SEQ_OFF : ARM_SEQ_OFF);

    // Shadow-window FSM next state: writeback flush wins, stall freezes
    always_comb begin
        w_state_nxt  = r_state;
        w_shadow_nxt = r_shadow_cnt;
        if (i_clear_from_writeback) begin
            w_state_nxt  = ST_RUN;
            w_shadow_nxt = 4'd0;
        end else if (!i_data_stall) begin
            case (r_state)
                ST_RUN: begin
                    if (w_accept && w_mispred) begin
                        w_state_nxt  = ST_SHADOW;
                        w_shadow_nxt = SHADOW_LOAD;
                    end
                end
                ST_SHADOW: begin
                    // Leave on the edge where the count reaches zero so that
                    // exactly SHADOW_CYCLES cycles of inputs are dropped
                    if (r_shadow_cnt <= 4'd1) begin
                        w_state_nxt  = ST_RUN;
                        w_shadow_nxt = 4'd0;
                    end else begin
                        w_shadow_nxt = r_shadow_cnt - 4'd1;
                    end
                end
                default: begin
                    w_state_nxt  = ST_RUN;
                    w_shadow_nxt = 4'd0;
                end
            endcase
        end
    end

    // FSM state register
    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            r_state      <= ST_RUN;
            r_shadow_cnt <= 4'd0;
        end else begin
            r_state      <= w_state_nxt;
            r_shadow_cnt <= w_shadow_nxt;
        end
    end

    // Registered training pulses and PCs; a stall holds even an asserted pulse
    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            r_clear    <= 1'b0;
            r_confirm  <= 1'b0;
            r_pc       <= 32'd0;
            r_redirect <= 32'd0;
        end else if (i_clear_from_writeback) begin
            r_clear    <= 1'b0;
            r_confirm  <= 1'b0;
        end else if (!i_data_stall) begin
            r_clear    <= w_accept & w_mispred;
            r_confirm  <= w_accept & ~w_mispred;
            if (w_accept)
                r_pc <= w_pc;
            if (w_accept && w_mispred)
                r_redirect <= i_taken ? i_target : w_seq;
        end
    end

    zap_sat_counter #(.W(32)) u_branch_cnt (
        .i_clk     (i_clk),
        .i_reset_n (i_reset_n),
        .i_en      (w_accept),
        .o_cnt     (o_branch_cnt)
    );

    zap_sat_counter #(.W(32)) u_mispredict_cnt (
        .i_clk     (i_clk),
        .i_reset_n (i_reset_n),
        .i_en      (w_accept & w_mispred),
        .o_cnt     (o_mispredict_cnt)
    );

    assign o_clear_from_alu   = r_clear;
    assign o_confirm_from_alu = r_confirm;
    assign o_pc_from_alu      = r_pc;
    assign o_redirect_pc      = r_redirect;

endmodule

// File: tb/tb_zap_branch_resolve.sv
// Directed, table-driven bench for zap_branch_resolve with SHADOW_CYCLES=2.
module tb_zap_branch_resolve;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        wbc, stl, val, br, taken, thumb;
    logic [1:0]  bst;
    logic [31:0] pc8, tgt;
    logic        o_clr, o_cfm;
    logic [31:0] o_pc, o_red, o_bc, o_mc;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    zap_branch_resolve #(.SHADOW_CYCLES(2)) dut (
        .i_clk                  (clk),
        .i_reset_n              (rst_n),
        .i_clear_from_writeback (wbc),
        .i_data_stall           (stl),
        .i_val                  (val),
        .i_is_branch            (br),
        .i_taken                (taken),
        .i_bstate               (bst),
        .i_thumb                (thumb),
        .i_pc_plus_8            (pc8),
        .i_target               (tgt),
        .o_clear_from_alu       (o_clr),
        .o_confirm_from_alu     (o_cfm),
        .o_pc_from_alu          (o_pc),
        .o_redirect_pc          (o_red),
        .o_branch_cnt           (o_bc),
        .o_mispredict_cnt       (o_mc)
    );

    typedef struct {
        logic        val, br, taken;
        logic [1:0]  bst;
        logic        thumb;
        logic [31:0] pc8, tgt;
        logic        wbc, stl;
        logic        e_clr, e_cfm;
        logic [31:0] e_pc, e_red, e_bc, e_mc;
    } vec_t;

    localparam int NV = 20;
    vec_t tbl [NV];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic drive(input logic v, input logic b, input logic t, input logic [1:0] s,
                         input logic th, input logic [31:0] p, input logic [31:0] g,
                         input logic w, input logic st);
        val = v; br = b; taken = t; bst = s; thumb = th; pc8 = p; tgt = g; wbc = w; stl = st;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_all(input string tag, input logic c, input logic f, input logic [31:0] p,
                           input logic [31:0] r, input logic [31:0] b, input logic [31:0] m);
        chk({tag, ".clear"},   {31'd0, o_clr}, {31'd0, c});
        chk({tag, ".confirm"}, {31'd0, o_cfm}, {31'd0, f});
        chk({tag, ".pc"},      o_pc, p);
        chk({tag, ".redirect"}, o_red, r);
        chk({tag, ".bcnt"},    o_bc, b);
        chk({tag, ".mcnt"},    o_mc, m);
    endtask

    initial begin
        // val br tk bst th pc8 tgt wbc stl | clr cfm pc red bcnt mcnt
        tbl[0]  = '{1'b1,1'b1,1'b1,2'd2,1'b0,32'h108,32'h400,1'b0,1'b0, 1'b0,1'b1,32'h100,32'h0,32'd1,32'd0};
        tbl[1]  = '{1'b1,1'b1,1'b0,2'd0,1'b0,32'h10C,32'h0,1'b0,1'b0, 1'b0,1'b1,32'h104,32'h0,32'd2,32'd0};
        tbl[2]  = '{1'b1,1'b0,1'b1,2'd3,1'b0,32'hF08,32'h0,1'b0,1'b0, 1'b0,1'b0,32'h104,32'h0,32'd2,32'd0};
        tbl[3]  = '{1'b1,1'b1,1'b1,2'd1,1'b0,32'h208,32'h800,1'b0,1'b0, 1'b1,1'b0,32'h200,32'h800,32'd3,32'd1};
        tbl[4]  = '{1'b1,1'b1,1'b1,2'd2,1'b0,32'h308,32'h0,1'b0,1'b0, 1'b0,1'b0,32'h200,32'h800,32'd3,32'd1};
        tbl[5]  = '{1'b1,1'b1,1'b0,2'd2,1'b0,32'h308,32'h0,1'b0,1'b0, 1'b0,1'b0,32'h200,32'h800,32'd3,32'd1};
        tbl[6]  = '{1'b1,1'b1,1'b1,2'd3,1'b0,32'h308,32'h0,1'b0,1'b0, 1'b0,1'b1,32'h300,32'h800,32'd4,32'd1};
        tbl[7]  = '{1'b1,1'b1,1'b0,2'd3,1'b1,32'h104,32'h0,1'b0,1'b0, 1'b1,1'b0,32'h100,32'h102,32'd5,32'd2};
        tbl[8]  = '{1'b0,1'b0,1'b0,2'd0,1'b0,32'h0,32'h0,1'b0,1'b0, 1'b0,1'b0,32'h100,32'h102,32'd5,32'd2};
        tbl[9]  = '{1'b0,1'b0,1'b0,2'd0,1'b0,32'h0,32'h0,1'b0,1'b0, 1'b0,1'b0,32'h100,32'h102,32'd5,32'd2};
        tbl[10] = '{1'b1,1'b1,1'b1,2'd0,1'b0,32'h508,32'h900,1'b1,1'b0, 1'b0,1'b0,32'h100,32'h102,32'd5,32'd2};
        tbl[11] = '{1'b1,1'b1,1'b1,2'd2,1'b0,32'h608,32'h0,1'b0,1'b0, 1'b0,1'b1,32'h600,32'h102,32'd6,32'd2};
        tbl[12] = '{1'b0,1'b1,1'b0,2'd3,1'b0,32'h708,32'h0,1'b0,1'b0, 1'b0,1'b0,32'h600,32'h102,32'd6,32'd2};
        tbl[13] = '{1'b1,1'b1,1'b1,2'd2,1'b1,32'h1004,32'h2000,1'b0,1'b0, 1'b0,1'b1,32'h1000,32'h102,32'd7,32'd2};
        tbl[14] = '{1'b1,1'b1,1'b0,2'd3,1'b0,32'h708,32'h0,1'b0,1'b0, 1'b1,1'b0,32'h700,32'h704,32'd8,32'd3};
        tbl[15] = '{1'b0,1'b0,1'b0,2'd0,1'b0,32'h0,32'h0,1'b1,1'b0, 1'b0,1'b0,32'h700,32'h704,32'd8,32'd3};
        tbl[16] = '{1'b1,1'b1,1'b0,2'd0,1'b0,32'h808,32'h0,1'b0,1'b0, 1'b0,1'b1,32'h800,32'h704,32'd9,32'd3};
        tbl[17] = '{1'b1,1'b1,1'b0,2'd3,1'b1,32'h2,32'h0,1'b0,1'b0, 1'b1,1'b0,32'hFFFF_FFFE,32'h0,32'd10,32'd4};
        tbl[18] = '{1'b0,1'b0,1'b0,2'd0,1'b0,32'h0,32'h0,1'b0,1'b0, 1'b0,1'b0,32'hFFFF_FFFE,32'h0,32'd10,32'd4};
        tbl[19] = '{1'b0,1'b0,1'b0,2'd0,1'b0,32'h0,32'h0,1'b0,1'b0, 1'b0,1'b0,32'hFFFF_FFFE,32'h0,32'd10,32'd4};

        drive(1'b0, 1'b0, 1'b0, 2'd0, 1'b0, 32'h0, 32'h0, 1'b0, 1'b0);
        rst_n = 1'b0;
        #12;
        chk_all("reset", 1'b0, 1'b0, 32'h0, 32'h0, 32'd0, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        // Table: main resolution, shadow window, writeback priority, wrap
        for (int i = 0; i < NV; i++) begin
            drive(tbl[i].val, tbl[i].br, tbl[i].taken, tbl[i].bst, tbl[i].thumb,
                  tbl[i].pc8, tbl[i].tgt, tbl[i].wbc, tbl[i].stl);
            step();
            chk_all($sformatf("vec%0d", i), tbl[i].e_clr, tbl[i].e_cfm, tbl[i].e_pc,
                    tbl[i].e_red, tbl[i].e_bc, tbl[i].e_mc);
        end

        // Clear held through a 3-cycle stall, branches during stall ignored
        drive(1'b1, 1'b1, 1'b1, 2'd0, 1'b0, 32'hA08, 32'hB00, 1'b0, 1'b0);
        step();
        chk_all("stall.pre", 1'b1, 1'b0, 32'hA00, 32'hB00, 32'd11, 32'd5);
        drive(1'b1, 1'b1, 1'b0, 2'd3, 1'b0, 32'hC08, 32'h0, 1'b0, 1'b1);
        for (int k = 0; k < 3; k++) begin
            step();
            chk_all($sformatf("stall.hold%0d", k), 1'b1, 1'b0, 32'hA00, 32'hB00, 32'd11, 32'd5);
        end
        drive(1'b0, 1'b0, 1'b0, 2'd0, 1'b0, 32'h0, 32'h0, 1'b0, 1'b0);
        step();
        chk_all("stall.drop", 1'b0, 1'b0, 32'hA00, 32'hB00, 32'd11, 32'd5);
        step();
        drive(1'b1, 1'b1, 1'b1, 2'd3, 1'b0, 32'hD08, 32'h0, 1'b0, 1'b0);
        step();
        chk_all("stall.after", 1'b0, 1'b1, 32'hD00, 32'hB00, 32'd12, 32'd5);

        // Branch counter saturation
        @(negedge clk);
        force dut.u_branch_cnt.r_cnt = 32'hFFFF_FFFE;
        #1;
        release dut.u_branch_cnt.r_cnt;
        drive(1'b1, 1'b1, 1'b1, 2'd2, 1'b0, 32'hE08, 32'h0, 1'b0, 1'b0);
        step();
        chk("sat.reach", o_bc, 32'hFFFF_FFFF);
        step();
        chk("sat.hold", o_bc, 32'hFFFF_FFFF);
        chk("sat.confirm", {31'd0, o_cfm}, 32'd1);

        // Asynchronous reset while in the shadow window
        drive(1'b1, 1'b1, 1'b0, 2'd2, 1'b0, 32'hF08, 32'h0, 1'b0, 1'b0);
        step();
        chk("shrst.clear", {31'd0, o_clr}, 32'd1);
        drive(1'b0, 1'b0, 1'b0, 2'd0, 1'b0, 32'h0, 32'h0, 1'b0, 1'b0);
        #2;
        rst_n = 1'b0;
        #1;
        chk_all("shrst.async", 1'b0, 1'b0, 32'h0, 32'h0, 32'd0, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        drive(1'b1, 1'b1, 1'b1, 2'd3, 1'b0, 32'h1108, 32'h0, 1'b0, 1'b0);
        step();
        chk_all("shrst.run", 1'b0, 1'b1, 32'h1100, 32'h0, 32'd1, 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
